// File: rtl/matmul_pkg.sv
// Shared sizes, FSM state type and run-timing constants for the 4x4 systolic matrix multiplier.
package matmul_pkg;
  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int AW   = 10;
  localparam int ACCW = 16;
  localparam int WW   = N * DW;
  localparam int CW   = 5;
  localparam int KW   = $clog2(N);

  // Cycle indices relative to the edge that samples start.
  localparam int READ_CYCLES = 4;
  localparam int WRITE_START = 12;
  localparam int DONE_CYCLE  = 16;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  function automatic logic [ACCW-1:0] mac_wrap(input logic [ACCW-1:0] acc,
                                               input logic [DW-1:0]   a,
                                               input logic [DW-1:0]   b);
    return acc + ACCW'(a) * ACCW'(b);
  endfunction
endpackage

// File: rtl/matmul_pe.sv
// Systolic MAC cell: accumulates a*b and forwards a east and b south one cycle later.
module matmul_pe
  import matmul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            acc_rst,
  input  logic [DW-1:0]   a_in,
  input  logic [DW-1:0]   b_in,
  output logic [DW-1:0]   a_out,
  output logic [DW-1:0]   b_out,
  output logic [ACCW-1:0] acc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
    end
  end

  // Accumulator has its own clear so it can be zeroed without disturbing the pipeline.
  always_ff @(posedge clk or posedge acc_rst) begin
    if (acc_rst) acc <= '0;
    else         acc <= mac_wrap(acc, a_in, b_in);
  end
endmodule

// File: rtl/matmul_ram.sv
// Single-port word RAM: synchronous write, registered read, contents never reset.
module matmul_ram
  import matmul_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [WW-1:0] wdata,
  output logic [WW-1:0] rdata
);
  logic [WW-1:0] ram [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) ram[addr] <= wdata;
    rdata <= ram[addr];
  end
endmodule

// File: rtl/matrix_multiplication.sv
// 4x4 systolic C = A x B over RAM-resident operands, with start/done handshake.
module matrix_multiplication
  import matmul_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          pe_resetn,
  input  logic [AW-1:0] address_mat_a,
  input  logic [AW-1:0] address_mat_b,
  input  logic [AW-1:0] address_mat_c,
  input  logic [7:0]    address_stride_a,
  input  logic [7:0]    address_stride_b,
  input  logic [7:0]    address_stride_c,
  input  logic [N-1:0]  validity_mask_a_rows,
  input  logic [N-1:0]  validity_mask_a_cols_b_rows,
  input  logic [N-1:0]  validity_mask_b_cols,
  input  logic          start_reg,
  input  logic          clear_done_reg,
  output logic          done_mat_mul
);
  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [KW-1:0]   idx;
  logic [AW-1:0]   addr_a, addr_b, addr_c;
  logic [WW-1:0]   a_word, b_word, c_wdata, c_rdata_unused;
  logic            c_we;
  logic            acc_rst;
  logic            rd_vld_p0;
  logic [KW-1:0]   rd_k_p0;
  logic [DW-1:0]   a_m [N];
  logic [DW-1:0]   b_m [N];
  logic [DW-1:0]   a_bus [N][N+1];
  logic [DW-1:0]   b_bus [N+1][N];
  logic [ACCW-1:0] acc [N][N];
  logic            edge_unused;

  assign idx          = cnt[KW-1:0];
  assign done_mat_mul = (state == DONE);
  assign acc_rst      = resetn | pe_resetn;
  assign c_we         = (state == WRITE);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start_reg) state_nxt = READ;
      end
      READ:  if (cnt == CW'(READ_CYCLES - 1)) state_nxt = DRAIN;
      DRAIN: if (cnt == CW'(WRITE_START - 1)) state_nxt = WRITE;
      WRITE: if (cnt == CW'(DONE_CYCLE - 1))  state_nxt = DONE;
      DONE: begin
        cnt_nxt = cnt;
        if (clear_done_reg) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // During READ idx is the inner index k; during WRITE (cnt 12..15) it is the C row.
  assign addr_a = address_mat_a + AW'(idx) * AW'(address_stride_a);
  assign addr_b = address_mat_b + AW'(idx) * AW'(address_stride_b);
  assign addr_c = address_mat_c + AW'(idx) * AW'(address_stride_c);

  matmul_ram matrix_A (.clk(clk), .we(1'b0), .addr(addr_a), .wdata('0),      .rdata(a_word));
  matmul_ram matrix_B (.clk(clk), .we(1'b0), .addr(addr_b), .wdata('0),      .rdata(b_word));
  matmul_ram matrix_C (.clk(clk), .we(c_we), .addr(addr_c), .wdata(c_wdata), .rdata(c_rdata_unused));

  // p0: RAM data returns one cycle after the READ address; tag it valid with its k.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) rd_vld_p0 <= 1'b0;
    else        rd_vld_p0 <= (state == READ);
  end

  always_ff @(posedge clk) rd_k_p0 <= idx;

  // Operands outside a valid read window are zero so idle cycles never accumulate.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_m[i] = '0;
      b_m[i] = '0;
      if (rd_vld_p0 && validity_mask_a_cols_b_rows[rd_k_p0]) begin
        if (validity_mask_a_rows[i]) a_m[i] = a_word[i*DW +: DW];
        if (validity_mask_b_cols[i]) b_m[i] = b_word[i*DW +: DW];
      end
    end
  end

  // p1: row i of A and column j of B are skewed by i and j cycles at the array edges.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_bus[0][0] = a_m[0];
      assign b_bus[0][0] = b_m[0];
    end else begin : g_delay
      logic [DW-1:0] a_skew_p1 [i];
      logic [DW-1:0] b_skew_p1 [i];
      always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
          for (int d = 0; d < i; d++) begin
            a_skew_p1[d] <= '0;
            b_skew_p1[d] <= '0;
          end
        end else begin
          a_skew_p1[0] <= a_m[i];
          b_skew_p1[0] <= b_m[i];
          for (int d = 1; d < i; d++) begin
            a_skew_p1[d] <= a_skew_p1[d-1];
            b_skew_p1[d] <= b_skew_p1[d-1];
          end
        end
      end
      assign a_bus[i][0] = a_skew_p1[i-1];
      assign b_bus[0][i] = b_skew_p1[i-1];
    end
  end

  // p2: the PE grid; a flows east along a_bus rows, b flows south along b_bus columns.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      matmul_pe u_pe (
        .clk    (clk),
        .rst    (resetn),
        .acc_rst(acc_rst),
        .a_in   (a_bus[i][j]),
        .b_in   (b_bus[i][j]),
        .a_out  (a_bus[i][j+1]),
        .b_out  (b_bus[i+1][j]),
        .acc    (acc[i][j])
      );
    end
  end

  always_comb begin
    c_wdata = '0;
    for (int j = 0; j < N; j++) c_wdata[j*DW +: DW] = acc[idx][j][DW-1:0];
  end

  // Array-edge outputs and upper accumulator bits have no consumer.
  always_comb begin
    edge_unused = 1'b0;
    for (int i = 0; i < N; i++) begin
      edge_unused = edge_unused ^ (^a_bus[i][N]) ^ (^b_bus[N][i]);
      for (int j = 0; j < N; j++) edge_unused = edge_unused ^ (^acc[i][j][ACCW-1:DW]);
    end
  end
endmodule

// File: tb/tb_matrix_multiplication.sv
// Directed bench for matrix_multiplication: preloads RAMs hierarchically and checks C and done timing.
module tb_matrix_multiplication;
  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       pe_resetn = 1'b0;
  logic [9:0] address_mat_a = '0, address_mat_b = '0, address_mat_c = '0;
  logic [7:0] address_stride_a = 8'd1, address_stride_b = 8'd1, address_stride_c = 8'd1;
  logic [3:0] validity_mask_a_rows = 4'hF, validity_mask_a_cols_b_rows = 4'hF, validity_mask_b_cols = 4'hF;
  logic       start_reg = 1'b0;
  logic       clear_done_reg = 1'b0;
  logic       done_mat_mul;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_col [4];
  logic [31:0] b_row [4];
  logic [31:0] c_exp [4];
  logic [31:0] c_mask2 [4];
  logic [31:0] sentinel = 32'hDEADBEEF;

  matrix_multiplication dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .pe_resetn                  (pe_resetn),
    .address_mat_a              (address_mat_a),
    .address_mat_b              (address_mat_b),
    .address_mat_c              (address_mat_c),
    .address_stride_a           (address_stride_a),
    .address_stride_b           (address_stride_b),
    .address_stride_c           (address_stride_c),
    .validity_mask_a_rows       (validity_mask_a_rows),
    .validity_mask_a_cols_b_rows(validity_mask_a_cols_b_rows),
    .validity_mask_b_cols       (validity_mask_b_cols),
    .start_reg                  (start_reg),
    .clear_done_reg             (clear_done_reg),
    .done_mat_mul               (done_mat_mul)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_cfg(input logic [9:0] ba, input logic [7:0] sa, input logic [9:0] bb,
                         input logic [7:0] sb, input logic [9:0] bc, input logic [7:0] sc);
    address_mat_a = ba; address_stride_a = sa;
    address_mat_b = bb; address_stride_b = sb;
    address_mat_c = bc; address_stride_c = sc;
  endtask

  task automatic load_mats(input logic [9:0] ba, input logic [9:0] sa, input logic [9:0] bb,
                           input logic [9:0] sb, input bit ones);
    for (int k = 0; k < 4; k++) begin
      dut.matrix_A.ram[ba + sa * 10'(k)] = ones ? 32'h01010101 : a_col[k];
      dut.matrix_B.ram[bb + sb * 10'(k)] = ones ? 32'h01010101 : b_row[k];
    end
  endtask

  task automatic pe_clear();
    @(negedge clk); pe_resetn = 1'b1;
    @(negedge clk); pe_resetn = 1'b0;
  endtask

  task automatic clear_done();
    @(negedge clk); clear_done_reg = 1'b1;
    @(negedge clk); clear_done_reg = 1'b0;
  endtask

  // Returns the number of rising edges after the start-sampling edge until done is seen, or -1.
  task automatic run(output int lat);
    lat = -1;
    @(negedge clk); start_reg = 1'b1;
    @(posedge clk); #1; start_reg = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done_mat_mul) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (done_mat_mul !== 1'b0) begin errors++; $display("FAIL reset_done_in_reset got %b want 0", done_mat_mul); end
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (done_mat_mul !== 1'b0) begin errors++; $display("FAIL reset_done_after got %b want 0", done_mat_mul); end
  endtask

  task automatic test_all_ones();
    int lat;
    set_cfg(10'd0, 8'd1, 10'd0, 8'd1, 10'd0, 8'd1);
    load_mats(10'd0, 10'd1, 10'd0, 10'd1, 1'b1);
    for (int r = 0; r < 4; r++) dut.matrix_C.ram[10'(r)] = '0;
    pe_clear();
    run(lat);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL ones_latency got %0d want 16", lat); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut.matrix_C.ram[10'(r)] !== 32'h04040404) begin
        errors++; $display("FAIL ones_row%0d got %h want %h", r, dut.matrix_C.ram[10'(r)], 32'h04040404);
      end
    end
    @(negedge clk);
    checks++;
    if (done_mat_mul !== 1'b1) begin errors++; $display("FAIL ones_done_sticky got %b want 1", done_mat_mul); end
    clear_done();
    checks++;
    if (done_mat_mul !== 1'b0) begin errors++; $display("FAIL ones_done_clear got %b want 0", done_mat_mul); end
  endtask

  task automatic test_accumulate();
    int lat;
    run(lat);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL accum_latency got %0d want 16", lat); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut.matrix_C.ram[10'(r)] !== 32'h08080808) begin
        errors++; $display("FAIL accum_row%0d got %h want %h", r, dut.matrix_C.ram[10'(r)], 32'h08080808);
      end
    end
    clear_done();
    pe_clear();
    run(lat);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut.matrix_C.ram[10'(r)] !== 32'h04040404) begin
        errors++; $display("FAIL accum_cleared_row%0d got %h want %h", r, dut.matrix_C.ram[10'(r)], 32'h04040404);
      end
    end
    clear_done();
  endtask

  task automatic test_matrix();
    int lat;
    load_mats(10'd0, 10'd1, 10'd0, 10'd1, 1'b0);
    pe_clear();
    run(lat);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL matrix_latency got %0d want 16", lat); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut.matrix_C.ram[10'(r)] !== c_exp[r]) begin
        errors++; $display("FAIL matrix_row%0d got %h want %h", r, dut.matrix_C.ram[10'(r)], c_exp[r]);
      end
    end
    clear_done();
  endtask

  task automatic test_mask();
    int lat;
    validity_mask_b_cols = 4'b0011;
    pe_clear();
    run(lat);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut.matrix_C.ram[10'(r)] !== (c_exp[r] & 32'h0000FFFF)) begin
        errors++; $display("FAIL maskb_row%0d got %h want %h", r, dut.matrix_C.ram[10'(r)], c_exp[r] & 32'h0000FFFF);
      end
    end
    clear_done();
    validity_mask_b_cols = 4'hF;
    validity_mask_a_rows = 4'b0101;
    validity_mask_a_cols_b_rows = 4'b1110;
    pe_clear();
    run(lat);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut.matrix_C.ram[10'(r)] !== c_mask2[r]) begin
        errors++; $display("FAIL maska_row%0d got %h want %h", r, dut.matrix_C.ram[10'(r)], c_mask2[r]);
      end
    end
    clear_done();
    validity_mask_a_rows = 4'hF;
    validity_mask_a_cols_b_rows = 4'hF;
  endtask

  task automatic test_stride();
    int lat;
    for (int a = 32; a < 48; a++) dut.matrix_C.ram[10'(a)] = sentinel;
    load_mats(10'd8, 10'd2, 10'd16, 10'd3, 1'b0);
    set_cfg(10'd8, 8'd2, 10'd16, 8'd3, 10'd32, 8'd4);
    pe_clear();
    run(lat);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL stride_latency got %0d want 16", lat); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut.matrix_C.ram[10'(32 + 4*r)] !== c_exp[r]) begin
        errors++; $display("FAIL stride_row%0d got %h want %h", r, dut.matrix_C.ram[10'(32 + 4*r)], c_exp[r]);
      end
    end
    for (int a = 33; a < 48; a += 5) begin
      checks++;
      if (dut.matrix_C.ram[10'(a)] !== sentinel) begin
        errors++; $display("FAIL stride_untouched_%0d got %h want %h", a, dut.matrix_C.ram[10'(a)], sentinel);
      end
    end
    clear_done();
    set_cfg(10'd0, 8'd1, 10'd0, 8'd1, 10'd0, 8'd1);
  endtask

  task automatic test_back_to_back();
    int lat;
    bit stayed;
    pe_clear();
    run(lat);
    for (int r = 0; r < 4; r++) dut.matrix_C.ram[10'(r)] = sentinel;
    @(negedge clk); start_reg = 1'b1;
    stayed = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_mat_mul !== 1'b1) stayed = 1'b0;
    end
    checks++;
    if (stayed !== 1'b1) begin errors++; $display("FAIL b2b_start_ignored got %b want 1", stayed); end
    checks++;
    if (dut.matrix_C.ram[10'd0] !== sentinel) begin
      errors++; $display("FAIL b2b_no_write_while_done got %h want %h", dut.matrix_C.ram[10'd0], sentinel);
    end
    pe_clear();
    @(negedge clk); clear_done_reg = 1'b1;
    @(posedge clk); #1; clear_done_reg = 1'b0;
    checks++;
    if (done_mat_mul !== 1'b0) begin errors++; $display("FAIL b2b_clear got %b want 0", done_mat_mul); end
    @(posedge clk); #1; start_reg = 1'b0;
    lat = -1;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done_mat_mul) begin lat = c; break; end
    end
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL b2b_latency got %0d want 17", lat); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut.matrix_C.ram[10'(r)] !== c_exp[r]) begin
        errors++; $display("FAIL b2b_row%0d got %h want %h", r, dut.matrix_C.ram[10'(r)], c_exp[r]);
      end
    end
    clear_done();
  endtask

  task automatic test_reset_midrun();
    int lat;
    bit stayed_low;
    for (int r = 0; r < 4; r++) dut.matrix_C.ram[10'(r)] = sentinel;
    @(negedge clk); start_reg = 1'b1;
    @(posedge clk); #1; start_reg = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); resetn = 1'b0;
    stayed_low = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (done_mat_mul !== 1'b0) stayed_low = 1'b0;
    end
    checks++;
    if (stayed_low !== 1'b1) begin errors++; $display("FAIL midrst_done_low got %b want 1", stayed_low); end
    checks++;
    if (dut.matrix_C.ram[10'd0] !== sentinel) begin
      errors++; $display("FAIL midrst_no_write got %h want %h", dut.matrix_C.ram[10'd0], sentinel);
    end
    run(lat);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL midrst_latency got %0d want 16", lat); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (dut.matrix_C.ram[10'(r)] !== c_exp[r]) begin
        errors++; $display("FAIL midrst_row%0d got %h want %h", r, dut.matrix_C.ram[10'(r)], c_exp[r]);
      end
    end
    clear_done();
  endtask

  initial begin
    a_col   = '{32'h09050308, 32'h01020304, 32'h00010306, 32'h05060708};
    b_row   = '{32'h00030101, 32'h03040100, 32'h01030503, 32'h02030609};
    c_exp   = '{32'h22525A62, 32'h1A333F4B, 32'h132C303E, 32'h0D2E2836};
    c_mask2 = '{32'h223A525A, 32'h00000000, 32'h131D2B39, 32'h00000000};
    test_reset();
    test_all_ones();
    test_accumulate();
    test_matrix();
    test_mask();
    test_stride();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_multiplication.md
Name: matrix_multiplication

Overview:
- 4x4 systolic matrix multiplier: computes C = A x B on 8-bit unsigned elements.
- Contains three internal 1024x32 RAMs: instance names matrix_A, matrix_B and matrix_C, each with storage array `ram`. Test benches preload and inspect these hierarchically.
- A 4x4 grid of MAC processing elements is fed with skewed operands. The block is controlled by a start/done register-style handshake from a host control block.

Parameters:
- DW, 8, element width.
- N, 4, array dimension (rows/cols/inner dimension).
- AW, 10, RAM address width (depth 2^AW words of N*DW bits).
- ACCW, 16, PE accumulator width.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-high global reset. Clears FSM, done, pipelines and PEs.
- pe_resetn  in  1  asynchronous, active-high clear of PE accumulators only.
- address_mat_a  in  10  base word address of A in matrix_A.
- address_mat_b  in  10  base word address of B in matrix_B.
- address_mat_c  in  10  base word address of C in matrix_C.
- address_stride_a  in  8  word stride between successive A words.
- address_stride_b  in  8  word stride between successive B words.
- address_stride_c  in  8  word stride between successive C words.
- validity_mask_a_rows  in  4  bit i=1: row i of A is valid.
- validity_mask_a_cols_b_rows  in  4  bit k=1: inner index k is valid.
- validity_mask_b_cols  in  4  bit j=1: column j of B is valid.
- start_reg  in  1  level start request.
- clear_done_reg  in  1  level clear of done.
- done_mat_mul  out  1  completion flag, sticky.

Behaviour:
- Storage layout (byte 0 = bits 7:0):
  - matrix_A word at address_mat_a + k*stride_a holds column k of A; byte i = A[i][k].
  - matrix_B word at address_mat_b + k*stride_b holds row k of B; byte j = B[k][j].
  - matrix_C word at address_mat_c + i*stride_c holds row i of C; byte j = C[i][j], low 8 bits of the accumulator.
- Address arithmetic wraps modulo 1024.
- RAMs: synchronous write, 1-cycle registered read. No reset of RAM contents.
- Masking: A byte i forced to 0 if mask_a_rows[i]=0. Whole A/B word k forced to 0 if mask_a_cols_b_rows[k]=0. B byte j forced to 0 if mask_b_cols[j]=0. Masked C entries are therefore written as 0 (on a cleared PE).
- FSM states: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE → READ when start_reg=1 and done_mat_mul=0. Edge at which start is sampled = cycle 0.
- READ, cycles 0-3: read A and B word k at cycle k.
- Skewed injection: data returns at cycle k+1. A row i is delayed i cycles at the west edge; B column j is delayed j cycles at the north edge.
- PE(i,j) each cycle:
  - acc += a_in*b_in (unsigned, ACCW bits, wraps).
  - Registers a to east neighbour and b to south neighbour.
  - Last product reaches PE(3,3) at cycle 10.
- DRAIN: cycles 4-11.
- WRITE: cycles 12-15, writing C row i at cycle 12+i.
- DONE: done_mat_mul goes high after the edge ending cycle 15, i.e. visible in cycle 16.
- done_mat_mul stays high until clear_done_reg=1, then clears on the next edge and FSM returns to IDLE.
- While done is high or a run is in progress, start_reg is ignored. A held start_reg after clear launches a new run.
- clear_done_reg during a run has no effect.
- Accumulators are NOT cleared at start. Successive runs accumulate unless pe_resetn is pulsed between them.
- Reset: resetn=1 at any time (including mid-run) → FSM IDLE, done_mat_mul=0, skew/pipe registers 0, accumulators 0. A partial C write is not undone.
- pe_resetn mid-run zeros the accumulators only; the FSM keeps running.

Decomposition:
- Shared package matmul_pkg: DW, N, AW, ACCW, FSM state enum, PE-edge cycle constants (READ_CYCLES=4, WRITE_START=12, DONE_CYCLE=16).
- Sub-module matmul_pe: MAC plus east/south forwarding registers; instanced N*N times.
- A trivial single-port RAM module, instanced as matrix_A, matrix_B, matrix_C with array `ram`.

Test Plan:
- All-ones A and B, bases 0, stride 1, masks 1111 → every matrix_C.ram[0..3] = 32'h04040404; done rises 16 cycles after start is sampled.
- A rows {8,4,6,8},{3,3,3,7},{5,2,1,6},{9,1,0,5}; B rows {1,1,3,0},{0,1,4,3},{3,5,3,1},{9,6,3,2} → C rows:
  - ram[0] = 32'h22525A62
  - ram[1] = 32'h1A333F4B
  - ram[2] = 32'h132C303E
  - ram[3] = 32'h0D2E2836
- Same data, mask_b_cols=0011, fresh pe_resetn → ram[0] = 32'h00005A62; columns 2-3 are zero in all rows.
- Base addresses A=8/B=16/C=32 with strides 2/3/4 → results at C addresses 32, 36, 40, 44; other C words unchanged.
- Second run without pe_resetn, all-ones → C bytes 8. Pulse pe_resetn then rerun → 4.
- resetn asserted at cycle 6 of a run → done stays 0, FSM IDLE. After deassert, start produces a correct result.
